// File: rtl/instr_fetch.sv
// instr_fetch: 8051 program-fetch stage; assembles 1-3 byte instructions from a 1-cycle synchronous ROM.
// Define INSTR_FETCH_ILLEGAL_EN to flag the reserved opcode 0xA5 on illegal_op while it is held.
module instr_fetch #(
    parameter int unsigned     PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b0}}
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [7:0]      instr_opcode,
    output logic [7:0]      instr_op1,
    output logic [7:0]      instr_op2,
    output logic [1:0]      instr_len,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] instr_next_pc,
    input  logic            jump_en,
    input  logic [PC_W-1:0] jump_addr,
    output logic            illegal_op
);

    localparam logic [PC_W-1:0] PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0] PC_TWO   = {{(PC_W-2){1'b0}}, 2'd2};
    localparam logic [PC_W-1:0] PC_THREE = {{(PC_W-2){1'b0}}, 2'd3};

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_BYTE0 = 3'd1,
        ST_BYTE1 = 3'd2,
        ST_BYTE2 = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // MCS-51 instruction length, indexed by opcode (low nibble selects the column family).
    function automatic logic [1:0] op_len(input logic [7:0] op);
        case (op[3:0])
            4'h0: case (op[7:4])
                4'h1, 4'h2, 4'h3, 4'h9: op_len = 2'd3;
                4'h0, 4'hE, 4'hF:       op_len = 2'd1;
                default:                op_len = 2'd2;
            endcase
            4'h1: op_len = 2'd2;
            4'h2: case (op[7:4])
                4'h0, 4'h1:             op_len = 2'd3;
                4'h2, 4'h3, 4'hE, 4'hF: op_len = 2'd1;
                default:                op_len = 2'd2;
            endcase
            4'h3: case (op[7:4])
                4'h4, 4'h5, 4'h6: op_len = 2'd3;
                default:          op_len = 2'd1;
            endcase
            4'h4: case (op[7:4])
                4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9: op_len = 2'd2;
                4'hB:                                     op_len = 2'd3;
                default:                                  op_len = 2'd1;
            endcase
            4'h5: case (op[7:4])
                4'h7, 4'h8, 4'hB, 4'hD: op_len = 2'd3;
                4'hA:                   op_len = 2'd1;
                default:                op_len = 2'd2;
            endcase
            4'h6, 4'h7: case (op[7:4])
                4'h7, 4'h8, 4'hA: op_len = 2'd2;
                4'hB:             op_len = 2'd3;
                default:          op_len = 2'd1;
            endcase
            default: case (op[7:4])
                4'h7, 4'h8, 4'hA, 4'hD: op_len = 2'd2;
                4'hB:                   op_len = 2'd3;
                default:                op_len = 2'd1;
            endcase
        endcase
    endfunction

    state_t          state_r;
    logic [PC_W-1:0] pc_r;
    logic [1:0]      len_s;
    logic [PC_W-1:0] len_ext_s;

    assign len_s     = op_len(rom_data);
    assign len_ext_s = {{(PC_W-2){1'b0}}, len_s};

    // Fetch FSM: rom_addr always runs one byte ahead of the byte being latched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r       <= ST_WAIT;
            pc_r          <= RESET_VEC;
            rom_addr      <= RESET_VEC;
            instr_valid   <= 1'b0;
            instr_opcode  <= 8'h00;
            instr_op1     <= 8'h00;
            instr_op2     <= 8'h00;
            instr_len     <= 2'd1;
            instr_pc      <= RESET_VEC;
            instr_next_pc <= RESET_VEC + PC_ONE;
        end else if (jump_en) begin
            // Redirect wins over everything, including a same-cycle accept.
            state_r     <= ST_WAIT;
            pc_r        <= jump_addr;
            rom_addr    <= jump_addr;
            instr_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    rom_addr <= pc_r + PC_ONE;
                    state_r  <= ST_BYTE0;
                end
                ST_BYTE0: begin
                    instr_opcode  <= rom_data;
                    instr_op1     <= 8'h00;
                    instr_op2     <= 8'h00;
                    instr_len     <= len_s;
                    instr_pc      <= pc_r;
                    instr_next_pc <= pc_r + len_ext_s;
                    if (len_s == 2'd1) begin
                        state_r     <= ST_HOLD;
                        instr_valid <= 1'b1;
                    end else begin
                        state_r  <= ST_BYTE1;
                        rom_addr <= pc_r + PC_TWO;
                    end
                end
                ST_BYTE1: begin
                    instr_op1 <= rom_data;
                    if (instr_len == 2'd2) begin
                        state_r     <= ST_HOLD;
                        instr_valid <= 1'b1;
                    end else begin
                        state_r  <= ST_BYTE2;
                        rom_addr <= pc_r + PC_THREE;
                    end
                end
                ST_BYTE2: begin
                    instr_op2   <= rom_data;
                    state_r     <= ST_HOLD;
                    instr_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        pc_r        <= instr_next_pc;
                        instr_valid <= 1'b0;
                        state_r     <= ST_WAIT;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_WAIT;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_FETCH_ILLEGAL_EN
    logic illegal_r;

    // 0xA5 is 1 byte long, so it goes straight from BYTE0 to HOLD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if (jump_en) begin
            illegal_r <= 1'b0;
        end else if ((state_r == ST_BYTE0) && (rom_data == 8'hA5)) begin
            illegal_r <= 1'b1;
        end else if ((state_r == ST_HOLD) && instr_ready) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal_op = illegal_r;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a behavioural 1-cycle synchronous ROM.
module tb_instr_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_op1;
    logic [7:0]  instr_op2;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic [15:0] instr_next_pc;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        illegal_op;

    logic [7:0]  rom [0:65535];
    int          checks = 0;
    int          failures = 0;

    instr_fetch #(.PC_W(16), .RESET_VEC(16'h0000)) dut (
        .clock         (clock),
        .reset         (reset),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_op1     (instr_op1),
        .instr_op2     (instr_op2),
        .instr_len     (instr_len),
        .instr_pc      (instr_pc),
        .instr_next_pc (instr_next_pc),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .illegal_op    (illegal_op)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic clear_rom;
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    endtask

    // Leaves the bench at the negedge of cycle 0 (the WAIT cycle after release).
    task automatic do_reset;
        reset = 1'b1; jump_en = 1'b0; jump_addr = 16'h0000; instr_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_rom();
        reset = 1'b1; jump_en = 1'b1; jump_addr = 16'h1234; instr_ready = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", instr_valid); end
        checks++; if (instr_opcode !== 8'h00) begin failures++; $display("FAIL rst_opcode got=%0h exp=0", instr_opcode); end
        checks++; if (instr_op1 !== 8'h00 || instr_op2 !== 8'h00) begin failures++; $display("FAIL rst_ops got=%0h/%0h exp=0/0", instr_op1, instr_op2); end
        checks++; if (instr_len !== 2'd1) begin failures++; $display("FAIL rst_len got=%0d exp=1", instr_len); end
        checks++; if (instr_pc !== 16'h0000) begin failures++; $display("FAIL rst_pc got=%0h exp=0", instr_pc); end
        checks++; if (instr_next_pc !== 16'h0001) begin failures++; $display("FAIL rst_next_pc got=%0h exp=1", instr_next_pc); end
        checks++; if (rom_addr !== 16'h0000) begin failures++; $display("FAIL rst_rom_addr got=%0h exp=0", rom_addr); end
        checks++; if (illegal_op !== 1'b0) begin failures++; $display("FAIL rst_illegal got=%0h exp=0", illegal_op); end
        jump_en = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checks++; if (rom_addr !== 16'h0001) begin failures++; $display("FAIL rst_first_fetch rom_addr got=%0h exp=1", rom_addr); end
    endtask

    task automatic test_nop;
        clear_rom();
        do_reset();
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL nop_c0_valid got=%0h exp=0", instr_valid); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL nop_c1_valid got=%0h exp=0", instr_valid); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL nop_c2_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr_opcode !== 8'h00 || instr_len !== 2'd1) begin failures++; $display("FAIL nop_op_len got=%0h/%0d exp=0/1", instr_opcode, instr_len); end
        checks++; if (instr_pc !== 16'h0000 || instr_next_pc !== 16'h0001) begin failures++; $display("FAIL nop_pcs got=%0h/%0h exp=0/1", instr_pc, instr_next_pc); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL nop_c3_valid got=%0h exp=0", instr_valid); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL nop_c4_valid got=%0h exp=0", instr_valid); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0001) begin failures++; $display("FAIL nop_c5_second got valid=%0h pc=%0h exp valid=1 pc=1", instr_valid, instr_pc); end
    endtask

    task automatic test_ljmp;
        clear_rom();
        rom[0] = 8'h02; rom[1] = 8'h12; rom[2] = 8'h34;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            checks++; if (rom_addr !== 16'(c)) begin failures++; $display("FAIL ljmp_rom_addr c%0d got=%0h exp=%0h", c, rom_addr, c); end
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ljmp_early_valid c%0d got=%0h exp=0", c, instr_valid); end
            @(negedge clock);
        end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL ljmp_valid got=%0h exp=1", instr_valid); end
        checks++; if (instr_opcode !== 8'h02 || instr_len !== 2'd3) begin failures++; $display("FAIL ljmp_op_len got=%0h/%0d exp=02/3", instr_opcode, instr_len); end
        checks++; if (instr_op1 !== 8'h12 || instr_op2 !== 8'h34) begin failures++; $display("FAIL ljmp_operands got=%0h/%0h exp=12/34", instr_op1, instr_op2); end
        checks++; if (instr_next_pc !== 16'h0003 || rom_addr !== 16'h0003) begin failures++; $display("FAIL ljmp_next got=%0h rom_addr=%0h exp=3/3", instr_next_pc, rom_addr); end
    endtask

    task automatic test_stall;
        clear_rom();
        rom[0] = 8'h74; rom[1] = 8'h55;
        do_reset();
        instr_ready = 1'b0;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL stall_valid k%0d got=%0h exp=1", k, instr_valid); end
            checks++; if (instr_opcode !== 8'h74 || instr_op1 !== 8'h55 || instr_op2 !== 8'h00) begin failures++; $display("FAIL stall_bytes k%0d got=%0h %0h %0h exp=74 55 00", k, instr_opcode, instr_op1, instr_op2); end
            checks++; if (instr_len !== 2'd2 || instr_pc !== 16'h0000 || instr_next_pc !== 16'h0002 || rom_addr !== 16'h0002) begin failures++; $display("FAIL stall_ctl k%0d got len=%0d pc=%0h next=%0h addr=%0h exp 2/0/2/2", k, instr_len, instr_pc, instr_next_pc, rom_addr); end
            @(negedge clock);
        end
        instr_ready = 1'b1;
        @(negedge clock);
        checks++; if (instr_valid !== 1'b0 || rom_addr !== 16'h0002) begin failures++; $display("FAIL stall_accept got valid=%0h addr=%0h exp 0/2", instr_valid, rom_addr); end
        repeat (2) @(negedge clock);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0002) begin failures++; $display("FAIL stall_next got valid=%0h pc=%0h exp 1/2", instr_valid, instr_pc); end
    endtask

    task automatic test_jump_mid;
        clear_rom();
        rom[0] = 8'h90; rom[1] = 8'hAB; rom[2] = 8'hCD; rom[16'h0100] = 8'hE4;
        do_reset();
        @(negedge clock);
        @(negedge clock);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL jmid_c2_valid got=%0h exp=0", instr_valid); end
        jump_en = 1'b1; jump_addr = 16'h0100;
        @(negedge clock);
        jump_en = 1'b0;
        checks++; if (instr_valid !== 1'b0 || rom_addr !== 16'h0100) begin failures++; $display("FAIL jmid_wait got valid=%0h addr=%0h exp 0/100", instr_valid, rom_addr); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL jmid_c4_valid got=%0h exp=0", instr_valid); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0100) begin failures++; $display("FAIL jmid_target got valid=%0h pc=%0h exp 1/100", instr_valid, instr_pc); end
        checks++; if (instr_opcode !== 8'hE4 || instr_len !== 2'd1 || instr_op1 !== 8'h00) begin failures++; $display("FAIL jmid_bytes got=%0h len=%0d op1=%0h exp E4/1/00", instr_opcode, instr_len, instr_op1); end
    endtask

    task automatic test_jump_accept;
        clear_rom();
        rom[16'h0200] = 8'h74; rom[16'h0201] = 8'h33;
        do_reset();
        repeat (2) @(negedge clock);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin failures++; $display("FAIL jacc_hold got valid=%0h pc=%0h exp 1/0", instr_valid, instr_pc); end
        jump_en = 1'b1; jump_addr = 16'h0200;
        @(negedge clock);
        jump_en = 1'b0;
        checks++; if (instr_valid !== 1'b0 || rom_addr !== 16'h0200) begin failures++; $display("FAIL jacc_wait got valid=%0h addr=%0h exp 0/200", instr_valid, rom_addr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL jacc_gap k%0d got=%0h exp=0", k, instr_valid); end
        end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0200 || instr_next_pc !== 16'h0202) begin failures++; $display("FAIL jacc_target got valid=%0h pc=%0h next=%0h exp 1/200/202", instr_valid, instr_pc, instr_next_pc); end
        checks++; if (instr_opcode !== 8'h74 || instr_op1 !== 8'h33) begin failures++; $display("FAIL jacc_bytes got=%0h %0h exp 74 33", instr_opcode, instr_op1); end
    endtask

    task automatic test_wrap;
        clear_rom();
        rom[16'hFFFE] = 8'h02; rom[16'hFFFF] = 8'hAB; rom[16'h0000] = 8'hCD;
        do_reset();
        jump_en = 1'b1; jump_addr = 16'hFFFE;
        @(negedge clock);
        jump_en = 1'b0;
        checks++; if (rom_addr !== 16'hFFFE) begin failures++; $display("FAIL wrap_a0 got=%0h exp=fffe", rom_addr); end
        @(negedge clock);
        checks++; if (rom_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_a1 got=%0h exp=ffff", rom_addr); end
        @(negedge clock);
        checks++; if (rom_addr !== 16'h0000) begin failures++; $display("FAIL wrap_a2 got=%0h exp=0", rom_addr); end
        @(negedge clock);
        checks++; if (rom_addr !== 16'h0001 || instr_valid !== 1'b0) begin failures++; $display("FAIL wrap_a3 got addr=%0h valid=%0h exp 1/0", rom_addr, instr_valid); end
        @(negedge clock);
        checks++; if (instr_valid !== 1'b1 || instr_len !== 2'd3) begin failures++; $display("FAIL wrap_valid got valid=%0h len=%0d exp 1/3", instr_valid, instr_len); end
        checks++; if (instr_op1 !== 8'hAB || instr_op2 !== 8'hCD) begin failures++; $display("FAIL wrap_ops got=%0h %0h exp AB CD", instr_op1, instr_op2); end
        checks++; if (instr_pc !== 16'hFFFE || instr_next_pc !== 16'h0001) begin failures++; $display("FAIL wrap_pcs got=%0h/%0h exp fffe/1", instr_pc, instr_next_pc); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  bt_op  [6];
        logic [7:0]  bt_op1 [6];
        logic [7:0]  bt_op2 [6];
        logic [1:0]  bt_len [6];
        logic [15:0] bt_pc  [6];
        logic        exp_ill;
        int          n;
        int          exp_n;
        bt_op  = '{8'h24, 8'hB4, 8'hA5, 8'h85, 8'hD8, 8'h12};
        bt_op1 = '{8'h11, 8'h22, 8'h00, 8'h44, 8'h66, 8'h34};
        bt_op2 = '{8'h00, 8'h33, 8'h00, 8'h55, 8'h00, 8'h56};
        bt_len = '{2'd2, 2'd3, 2'd1, 2'd3, 2'd2, 2'd3};
        bt_pc  = '{16'd0, 16'd2, 16'd5, 16'd6, 16'd9, 16'd11};
        clear_rom();
        for (int k = 0; k < 6; k++) begin
            rom[bt_pc[k]] = bt_op[k];
            if (bt_len[k] > 2'd1) rom[bt_pc[k] + 16'd1] = bt_op1[k];
            if (bt_len[k] > 2'd2) rom[bt_pc[k] + 16'd2] = bt_op2[k];
        end
        do_reset();
        for (int k = 0; k < 6; k++) begin
            n = (k == 0) ? 0 : 1;
            while (instr_valid !== 1'b1 && n < 12) begin
                @(negedge clock);
                n++;
            end
            exp_n = int'(bt_len[k]) + ((k == 0) ? 1 : 2);
`ifdef INSTR_FETCH_ILLEGAL_EN
            exp_ill = (bt_op[k] == 8'hA5);
`else
            exp_ill = 1'b0;
`endif
            checks++; if (n !== exp_n) begin failures++; $display("FAIL b2b_latency k%0d got=%0d exp=%0d", k, n, exp_n); end
            checks++; if (instr_valid !== 1'b1 || instr_pc !== bt_pc[k] || instr_len !== bt_len[k]) begin failures++; $display("FAIL b2b_hdr k%0d got valid=%0h pc=%0h len=%0d exp 1/%0h/%0d", k, instr_valid, instr_pc, instr_len, bt_pc[k], bt_len[k]); end
            checks++; if (instr_opcode !== bt_op[k] || instr_op1 !== bt_op1[k] || instr_op2 !== bt_op2[k]) begin failures++; $display("FAIL b2b_bytes k%0d got=%0h %0h %0h exp=%0h %0h %0h", k, instr_opcode, instr_op1, instr_op2, bt_op[k], bt_op1[k], bt_op2[k]); end
            checks++; if (instr_next_pc !== bt_pc[k] + {14'd0, bt_len[k]}) begin failures++; $display("FAIL b2b_next k%0d got=%0h exp=%0h", k, instr_next_pc, bt_pc[k] + {14'd0, bt_len[k]}); end
            checks++; if (illegal_op !== exp_ill) begin failures++; $display("FAIL b2b_illegal k%0d got=%0h exp=%0h", k, illegal_op, exp_ill); end
            @(negedge clock);
            checks++; if (instr_valid !== 1'b0 || illegal_op !== 1'b0) begin failures++; $display("FAIL b2b_after_accept k%0d got valid=%0h ill=%0h exp 0/0", k, instr_valid, illegal_op); end
        end
    endtask

    initial begin
        reset = 1'b1; jump_en = 1'b0; jump_addr = 16'h0000; instr_ready = 1'b1;
        test_reset();
        test_nop();
        test_ljmp();
        test_stall();
        test_jump_mid();
        test_jump_accept();
        test_wrap();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
